// File: rtl/freq_counter_bcd.sv
// Gated frequency counter: counts selected input edges over a loadable gate period,
// then converts the count to packed BCD with a bit-serial double-dabble.
module freq_counter_bcd #(
  parameter int DIGITS         = 4,
  parameter int PERIOD_BITS    = 24,
  parameter int DEFAULT_PERIOD = 12000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   signal,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic                   period_load,
  input  logic [1:0]             edge_mode,
  output logic [4*DIGITS-1:0]    bcd_out,
  output logic                   overflow,
  output logic                   valid,
  output logic                   busy
);
  localparam int CBITS = 4 * DIGITS;
  localparam int SBITS = $clog2(CBITS);

  function automatic logic [CBITS-1:0] pow10(input int n);
    logic [CBITS-1:0] r;
    r = CBITS'(1);
    for (int i = 0; i < n; i++) r = r * CBITS'(10);
    return r;
  endfunction

  localparam logic [CBITS-1:0]       FULL_SCALE = pow10(DIGITS);
  localparam logic [PERIOD_BITS-1:0] ONE        = PERIOD_BITS'(1);

  typedef enum logic [1:0] {COUNT = 2'd0, CONVERT = 2'd1, LATCH = 2'd2} state_t;

  state_t                 state_reg;
  logic                   q0, q1, q2;
  logic [1:0]             mode_reg;
  logic [PERIOD_BITS-1:0] clk_cnt_reg;
  logic [PERIOD_BITS-1:0] gate_period_reg;
  logic [PERIOD_BITS-1:0] pend_period_reg;
  logic                   pend_valid_reg;
  logic [CBITS-1:0]       edge_cnt_reg;
  logic                   ovf_reg;
  logic [CBITS-1:0]       bin_reg;
  logic [CBITS-1:0]       bcd_reg;
  logic [SBITS-1:0]       bit_cnt_reg;

  logic                   rise, fall, hit;
  logic [CBITS-1:0]       cnt_next;
  logic                   ovf_next;
  logic [CBITS-1:0]       bcd_adj;

  assign rise = q1 & ~q2;
  assign fall = ~q1 & q2;

  always_comb begin
    hit = rise;
    case (mode_reg)
      2'b01:   hit = fall;
      2'b10:   hit = rise | fall;
      default: hit = rise;
    endcase
  end

  // The count sticks at full scale; the last gate cycle's edge is folded in before conversion.
  always_comb begin
    cnt_next = edge_cnt_reg;
    if (hit && edge_cnt_reg != FULL_SCALE) cnt_next = edge_cnt_reg + 1'b1;
    ovf_next = ovf_reg | (cnt_next == FULL_SCALE);
  end

  genvar gi;
  for (gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                             : bcd_reg[4*gi +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= COUNT;
      q0              <= 1'b0;
      q1              <= 1'b0;
      q2              <= 1'b0;
      mode_reg        <= edge_mode;
      clk_cnt_reg     <= '0;
      gate_period_reg <= PERIOD_BITS'(DEFAULT_PERIOD);
      pend_period_reg <= '0;
      pend_valid_reg  <= 1'b0;
      edge_cnt_reg    <= '0;
      ovf_reg         <= 1'b0;
      bin_reg         <= '0;
      bcd_reg         <= '0;
      bit_cnt_reg     <= '0;
      bcd_out         <= '0;
      overflow        <= 1'b0;
      valid           <= 1'b0;
      busy            <= 1'b0;
    end else begin
      q0    <= signal;
      q1    <= q0;
      q2    <= q1;
      valid <= 1'b0;
      case (state_reg)
        COUNT: begin
          edge_cnt_reg <= cnt_next;
          ovf_reg      <= ovf_next;
          if (clk_cnt_reg == gate_period_reg - ONE) begin
            clk_cnt_reg <= '0;
            bin_reg     <= ovf_next ? FULL_SCALE - 1'b1 : cnt_next;
            bcd_reg     <= '0;
            bit_cnt_reg <= '0;
            busy        <= 1'b1;
            state_reg   <= CONVERT;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + ONE;
          end
        end
        CONVERT: begin
          {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
          bit_cnt_reg        <= bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == SBITS'(CBITS - 1)) state_reg <= LATCH;
        end
        LATCH: begin
          bcd_out      <= bcd_reg;
          overflow     <= ovf_reg;
          valid        <= 1'b1;
          busy         <= 1'b0;
          edge_cnt_reg <= '0;
          ovf_reg      <= 1'b0;
          mode_reg     <= edge_mode;
          if (pend_valid_reg) gate_period_reg <= pend_period_reg;
          pend_valid_reg <= 1'b0;
          state_reg      <= COUNT;
        end
        default: begin
          edge_cnt_reg <= '0;
          ovf_reg      <= 1'b0;
          clk_cnt_reg  <= '0;
          busy         <= 1'b0;
          state_reg    <= COUNT;
        end
      endcase
      // A load arriving on the LATCH cycle stays pending for the following gate.
      if (period_load) begin
        pend_period_reg <= (period == '0) ? ONE : period;
        pend_valid_reg  <= 1'b1;
      end
    end
  end
endmodule
